// File: rtl/ah_stream_accum.sv
// Streaming accumulator: launches a read-master job, folds each buffered word
// into a sum/max/xor accumulator and reports the result with a done pulse.
module ah_stream_accum #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 25,
  parameter int ACC_W  = 40
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       read_addr,
  input  logic [31:0]       size,
  input  logic [1:0]        mode,
  input  logic              read_en,
  output logic [ACC_W-1:0]  result,
  output logic              done,
  output logic              busy,
  output logic              overflow,
  output logic              control_fixed_location,
  output logic [ADDR_W-1:0] control_read_base,
  output logic [ADDR_W-1:0] control_read_length,
  output logic              control_go,
  input  logic              control_done,
  input  logic [DATA_W-1:0] user_buffer_data,
  input  logic              user_data_available,
  output logic              user_read_buffer
);

  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_STREAM = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t             state_q;
  logic [1:0]         mode_q;
  logic [31:0]        words_q;
  logic [ACC_W-1:0]   acc_q;
  logic               ovf_q;
  logic [ACC_W-1:0]   result_q;
  logic               done_q;
  logic               go_q;
  logic [ADDR_W-1:0]  base_q;
  logic [ADDR_W-1:0]  len_q;
  logic               cdone_q;

  logic [ACC_W-1:0]   acc_d;
  logic               carry_d;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   data_ext;
  logic [31:0]        words_init;
  logic               pop;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^read_addr[31:ADDR_W];

  assign words_init = size / 32'(BYTES_PER_WORD);
  assign pop        = !reset && (state_q == ST_STREAM) && user_data_available
                      && (words_q != '0);

  always_comb begin
    data_ext = ACC_W'(user_buffer_data);
    sum_ext  = {1'b0, acc_q} + {1'b0, data_ext};
    acc_d    = sum_ext[ACC_W-1:0];
    carry_d  = 1'b0;
    case (mode_q)
      2'd1:    acc_d = (data_ext > acc_q) ? data_ext : acc_q;
      2'd2:    acc_d = acc_q ^ data_ext;
      default: carry_d = sum_ext[ACC_W];  // mode 3 behaves as sum
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= '0;
      words_q  <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      go_q     <= 1'b0;
      base_q   <= '0;
      len_q    <= '0;
      cdone_q  <= 1'b0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read_en) begin
            base_q  <= read_addr[ADDR_W-1:0];
            len_q   <= size[ADDR_W-1:0];
            mode_q  <= mode;
            words_q <= words_init;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cdone_q <= 1'b0;
            if (words_init == '0) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_LAUNCH;
              go_q    <= 1'b1;
            end
          end
        end
        ST_LAUNCH: begin
          cdone_q <= cdone_q | control_done;
          state_q <= ST_STREAM;
        end
        ST_STREAM: begin
          // control_done may arrive before the buffer drains; remember it
          cdone_q <= cdone_q | control_done;
          if (pop) begin
            acc_q   <= acc_d;
            ovf_q   <= ovf_q | carry_d;
            words_q <= words_q - 32'd1;
          end
          if ((words_q == '0) && (cdone_q || control_done)) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          result_q <= acc_q;
          done_q   <= 1'b1;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign result                 = result_q;
  assign done                   = done_q;
  assign busy                   = (state_q != ST_IDLE);
  assign overflow               = ovf_q;
  assign control_fixed_location = 1'b0;
  assign control_read_base      = base_q;
  assign control_read_length    = len_q;
  assign control_go             = go_q;
  assign user_read_buffer       = pop;

endmodule

// File: tb/tb_ah_stream_accum.sv
// Randomized bench for ah_stream_accum with a queue-based read buffer and an
// arithmetic reference model of the sum/max/xor reduction.
module tb_ah_stream_accum;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] read_addr = '0;
  logic [31:0] size = '0;
  logic [1:0]  mode = '0;
  logic        read_en = 1'b0;
  logic [31:0] result;
  logic        done, busy, overflow, control_fixed_location, control_go;
  logic [24:0] control_read_base, control_read_length;
  logic        control_done = 1'b0;
  logic [31:0] user_buffer_data = '0;
  logic        user_data_available = 1'b0;
  logic        user_read_buffer;

  ah_stream_accum #(.DATA_W(32), .ADDR_W(25), .ACC_W(32)) dut (
    .clock(clock), .reset(reset), .read_addr(read_addr), .size(size),
    .mode(mode), .read_en(read_en), .result(result), .done(done),
    .busy(busy), .overflow(overflow),
    .control_fixed_location(control_fixed_location),
    .control_read_base(control_read_base),
    .control_read_length(control_read_length), .control_go(control_go),
    .control_done(control_done), .user_buffer_data(user_buffer_data),
    .user_data_available(user_data_available),
    .user_read_buffer(user_read_buffer)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;
  int go_cnt = 0, pop_cnt = 0, done_cnt = 0;
  logic [31:0] buf_q[$];
  bit stall = 1'b0;

  logic        s_done, s_busy, s_go, s_pop, s_ovf, s_fixed;
  logic [31:0] s_result;
  logic [24:0] s_base, s_len;

  function automatic logic [32:0] ref_model(input logic [1:0] m,
                                            input logic [31:0] w[$], input int n);
    longint unsigned acc = 0;
    bit ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (m)
        2'd1: if (longint'(w[i]) > acc) acc = longint'(w[i]);
        2'd2: acc = acc ^ longint'(w[i]);
        default: begin
          acc = acc + longint'(w[i]);
          if (acc >= 64'h1_0000_0000) begin
            acc = acc - 64'h1_0000_0000;
            ovf = 1'b1;
          end
        end
      endcase
    end
    return {ovf, acc[31:0]};
  endfunction

  task automatic refresh();
    user_data_available = !stall && (buf_q.size() > 0);
    user_buffer_data    = (buf_q.size() > 0) ? buf_q[0] : 32'h0;
  endtask

  // One clock: snapshot outputs mid-cycle, then apply the pop after the edge.
  task automatic cycle();
    @(negedge clock);
    s_done = done; s_busy = busy; s_go = control_go; s_pop = user_read_buffer;
    s_ovf = overflow; s_result = result; s_base = control_read_base;
    s_len = control_read_length; s_fixed = control_fixed_location;
    if (s_go) go_cnt++;
    if (s_pop) pop_cnt++;
    if (s_done) done_cnt++;
    @(posedge clock);
    #1;
    if (s_pop && buf_q.size() > 0) void'(buf_q.pop_front());
    refresh();
  endtask

  task automatic do_job(input string name, input logic [1:0] m,
                        input logic [31:0] addr, input logic [31:0] sz,
                        input logic [31:0] w[$], input int nextra,
                        input bit early_cd, input bit stall_en, input bit poke);
    int nw, go0, pop0, done0;
    bit got_done, cd_sent;
    logic [32:0] exp;
    nw = int'(sz / 32'd4);
    exp = ref_model(m, w, nw);
    buf_q.delete();
    for (int i = 0; i < nw; i++) buf_q.push_back(w[i]);
    for (int i = 0; i < nextra; i++) buf_q.push_back($urandom);
    stall = 1'b0;
    refresh();
    go0 = go_cnt; pop0 = pop_cnt; done0 = done_cnt;
    got_done = 1'b0; cd_sent = 1'b0;
    read_addr = addr; size = sz; mode = m; read_en = 1'b1;
    cycle();
    read_en = 1'b0;
    if (nw == 0) begin
      cycle();
      total++;
      if (s_busy !== 1'b1 || s_done !== 1'b0 || s_go !== 1'b0)
        $display("FAIL %s zero_len_finish busy=%b done=%b go=%b want 1/0/0", name, s_busy, s_done, s_go);
      else passed++;
      cycle();
      got_done = (s_done === 1'b1);
    end else begin
      cycle();
      total++;
      if (s_go !== 1'b1 || s_busy !== 1'b1)
        $display("FAIL %s go_latency go=%b busy=%b want 1/1", name, s_go, s_busy);
      else passed++;
      for (int k = 0; k < 300 && !got_done; k++) begin
        if (early_cd) control_done = (k == 0);
        else begin
          control_done = !cd_sent && (pop_cnt - pop0 == nw);
          if (control_done) cd_sent = 1'b1;
        end
        stall = stall_en && (k >= 1) && (k < 6);
        if (poke && k == 0) begin
          read_en = 1'b1; read_addr = ~addr; size = 32'h40; mode = m ^ 2'd1;
        end else read_en = 1'b0;
        refresh();
        cycle();
        if (s_done === 1'b1) got_done = 1'b1;
      end
      control_done = 1'b0; stall = 1'b0; read_en = 1'b0;
      refresh();
    end
    total++;
    if (!got_done) $display("FAIL %s done_timeout got_done=0 want 1", name);
    else passed++;
    total++;
    if (s_result !== exp[31:0])
      $display("FAIL %s result got=%h want=%h", name, s_result, exp[31:0]);
    else passed++;
    total++;
    if (s_ovf !== exp[32])
      $display("FAIL %s overflow got=%b want=%b", name, s_ovf, exp[32]);
    else passed++;
    total++;
    if (pop_cnt - pop0 != nw || buf_q.size() != nextra)
      $display("FAIL %s pops got=%0d left=%0d want %0d/%0d", name, pop_cnt - pop0, buf_q.size(), nw, nextra);
    else passed++;
    total++;
    if (go_cnt - go0 != ((nw > 0) ? 1 : 0))
      $display("FAIL %s go_count got=%0d want=%0d", name, go_cnt - go0, (nw > 0) ? 1 : 0);
    else passed++;
    total++;
    if (s_base !== addr[24:0] || s_len !== sz[24:0])
      $display("FAIL %s latched base=%h len=%h want %h/%h", name, s_base, s_len, addr[24:0], sz[24:0]);
    else passed++;
    cycle();
    total++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || s_result !== exp[31:0] || done_cnt - done0 != 1)
      $display("FAIL %s after_done done=%b busy=%b result=%h pulses=%0d want 0/0/%h/1", name, s_done, s_busy, s_result, done_cnt - done0, exp[31:0]);
    else passed++;
    buf_q.delete();
    refresh();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cycle(); cycle();
    total++;
    if ({s_done, s_busy, s_go, s_pop, s_ovf, s_fixed} !== 6'b0 || s_result !== 32'h0 ||
        s_base !== 25'h0 || s_len !== 25'h0)
      $display("FAIL reset_state done=%b busy=%b go=%b pop=%b ovf=%b fixed=%b result=%h base=%h len=%h want all 0",
               s_done, s_busy, s_go, s_pop, s_ovf, s_fixed, s_result, s_base, s_len);
    else passed++;
    reset = 1'b0;
    cycle();
  endtask

  task automatic test_sum();
    logic [31:0] w[$] = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_job("sum4", 2'd0, 32'h0000_1000, 32'd16, w, 2, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_max_xor();
    logic [31:0] w[$] = '{32'd5, 32'hFFFF_FFFF, 32'd7};
    do_job("max3", 2'd1, 32'h0000_2000, 32'd12, w, 1, 1'b0, 1'b0, 1'b0);
    do_job("xor3", 2'd2, 32'h0000_2000, 32'd12, w, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_zero_length();
    logic [31:0] w[$] = '{32'd9};
    do_job("zero_len", 2'd0, 32'h0000_3000, 32'd3, w, 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    logic [31:0] w1[$] = '{32'hFFFF_FFFF, 32'd2};
    logic [31:0] w2[$] = '{32'd1, 32'd1};
    do_job("ovf_set", 2'd0, 32'h0000_4000, 32'd8, w1, 0, 1'b0, 1'b0, 1'b0);
    do_job("ovf_clear", 2'd3, 32'h0000_4000, 32'd8, w2, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_early_done_stall();
    logic [31:0] w[$] = '{32'd100, 32'd200, 32'd300, 32'd400};
    do_job("early_cd_stall", 2'd0, 32'h0000_5000, 32'd18, w, 1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    logic [31:0] w[$] = '{32'd5, 32'd6, 32'd7, 32'd8};
    int pop0;
    bit reached;
    buf_q.delete();
    buf_q.push_back(32'd11); buf_q.push_back(32'd22);
    refresh();
    pop0 = pop_cnt;
    read_addr = 32'h0000_6000; size = 32'd16; mode = 2'd0; read_en = 1'b1;
    cycle();
    read_en = 1'b0;
    reached = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      cycle();
      reached = (pop_cnt - pop0 == 2);
    end
    total++;
    if (!reached) $display("FAIL mid_reset_prepops got=%0d want 2", pop_cnt - pop0);
    else passed++;
    buf_q.push_back(32'd33); buf_q.push_back(32'd44);
    reset = 1'b1;
    refresh();
    cycle(); cycle();
    total++;
    if ({s_done, s_busy, s_go, s_pop, s_ovf} !== 5'b0 || s_result !== 32'h0 ||
        s_base !== 25'h0 || s_len !== 25'h0 || buf_q.size() != 2)
      $display("FAIL mid_reset_outputs done=%b busy=%b go=%b pop=%b ovf=%b result=%h base=%h len=%h left=%0d want all 0, left 2",
               s_done, s_busy, s_go, s_pop, s_ovf, s_result, s_base, s_len, buf_q.size());
    else passed++;
    reset = 1'b0;
    buf_q.delete();
    refresh();
    cycle();
    do_job("after_reset", 2'd0, 32'h0000_7000, 32'd16, w, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int j = 0; j < 16; j++) begin
      logic [31:0] w[$];
      int nw;
      logic [31:0] sz;
      nw = int'($urandom_range(0, 6));
      for (int i = 0; i < nw; i++)
        w.push_back(($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 255)));
      sz = 32'(nw * 4) + 32'($urandom_range(0, 3));
      do_job($sformatf("rand%0d", j), 2'($urandom_range(0, 3)), $urandom, sz, w,
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w1[$] = '{32'h8000_0000, 32'h8000_0001};
    logic [31:0] w2[$] = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h1234_5678};
    do_job("b2b_a", 2'd3, 32'h01AB_CDEF, 32'd8, w1, 0, 1'b0, 1'b0, 1'b0);
    do_job("b2b_b", 2'd2, 32'hFFFF_FFF0, 32'd12, w2, 0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    refresh();
    test_reset();
    test_sum();
    test_max_xor();
    test_zero_length();
    test_overflow();
    test_early_done_stall();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end

endmodule
